// File: rtl/uart_pkg.sv
// Shared UART framing constants, state encodings and byte helpers used by
// both the nonce transmit path and the block-header receive path.
package uart_pkg;

  // 50 MHz UART clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int FRAME_BYTES = 6;

  // Line / frame state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // XOR checksum over the four nonce bytes (sync byte excluded)
  function automatic logic [7:0] nonceChecksum(input logic [31:0] n);
    return n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
  endfunction

  // Byte idx of a frame: sync, nonce MSB first, checksum
  function automatic logic [7:0] frameByte(input logic [2:0] idx, input logic [7:0] sync,
                                           input logic [31:0] n, input logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = n[31:24];
      3'd2:    b = n[23:16];
      3'd3:    b = n[15:8];
      3'd4:    b = n[7:0];
      3'd5:    b = chk;
      default: b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake. ready is also raised in
// the final stop-bit cycle so the next byte's start bit follows with no gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  bitState;
  logic [15:0] baudCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic        txdReg;
  logic        baudWrap;

  assign baudWrap = (baudCnt == BAUD_LAST);
  assign txd      = txdReg;

  // Accept a byte when idle or in the last cycle of the stop bit
  always_comb begin
    ready = 1'b0;
    if (bitState == ST_IDLE) begin
      ready = 1'b1;
    end else if ((bitState == ST_STOP) && baudWrap) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
  end

  // Bit sequencing: start, 8 data bits LSB first, stop; each CLKS_PER_BIT long
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitState <= ST_IDLE;
      baudCnt  <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
      txdReg   <= 1'b1;
    end else if (valid && ready) begin
      bitState <= ST_START;
      baudCnt  <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= data;
      txdReg   <= 1'b0;
    end else begin
      case (bitState)
        ST_IDLE: begin
          baudCnt <= 16'd0;
          txdReg  <= 1'b1;
        end
        ST_START: begin
          if (baudWrap) begin
            baudCnt  <= 16'd0;
            bitIdx   <= 3'd0;
            bitState <= ST_DATA;
            txdReg   <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baudWrap) begin
            baudCnt <= 16'd0;
            if (bitIdx == 3'd7) begin
              bitState <= ST_STOP;
              txdReg   <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              txdReg   <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baudWrap) begin
            baudCnt  <= 16'd0;
            bitState <= ST_IDLE;
            txdReg   <= 1'b1;
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        default: begin
          bitState <= ST_IDLE;
          baudCnt  <= 16'd0;
          txdReg   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/nonce_uart_tx.sv
// Golden-nonce transmitter: sequences the 6-byte frame (sync, nonce MSB
// first, XOR checksum) into uart_tx_byte and generates busy/done.
module nonce_uart_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] nonce,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  // frameState uses IDLE / DATA (bytes in flight) / DONE
  logic [2:0]  frameState;
  logic [2:0]  byteIdx;
  logic [31:0] nonceReg;
  logic [7:0]  checksumReg;
  logic        busyReg;
  logic        doneReg;
  logic        byteValid;
  logic        byteReady;
  logic [7:0]  byteData;

  assign busy = busyReg;
  assign done = doneReg;

  // Byte handoff: sync byte on accept, then bytes 1..5 from the latched nonce
  always_comb begin
    byteValid = 1'b0;
    byteData  = SYNC_BYTE;
    case (frameState)
      ST_IDLE, ST_DONE: begin
        byteValid = send;
        byteData  = SYNC_BYTE;
      end
      ST_DATA: begin
        if (byteIdx < LAST_BYTE) begin
          byteValid = 1'b1;
          byteData  = frameByte(byteIdx + 3'd1, SYNC_BYTE, nonceReg, checksumReg);
        end else begin
          byteValid = 1'b0;
          byteData  = SYNC_BYTE;
        end
      end
      default: begin
        byteValid = 1'b0;
        byteData  = SYNC_BYTE;
      end
    endcase
  end

  // Frame sequencing; DONE is accept-ready so frames can run back to back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameState  <= ST_IDLE;
      byteIdx     <= 3'd0;
      nonceReg    <= 32'd0;
      checksumReg <= 8'd0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      case (frameState)
        ST_IDLE, ST_DONE: begin
          doneReg <= 1'b0;
          byteIdx <= 3'd0;
          if (send) begin
            frameState  <= ST_DATA;
            nonceReg    <= nonce;
            checksumReg <= nonceChecksum(nonce);
            busyReg     <= 1'b1;
          end else begin
            frameState <= ST_IDLE;
            busyReg    <= 1'b0;
          end
        end
        ST_DATA: begin
          doneReg <= 1'b0;
          if (byteReady) begin
            if (byteIdx == LAST_BYTE) begin
              frameState <= ST_DONE;
              byteIdx    <= 3'd0;
              busyReg    <= 1'b0;
              doneReg    <= 1'b1;
            end else begin
              byteIdx <= byteIdx + 3'd1;
            end
          end else begin
            byteIdx <= byteIdx;
          end
        end
        default: begin
          frameState <= ST_IDLE;
          byteIdx    <= 3'd0;
          busyReg    <= 1'b0;
          doneReg    <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_txByte (
    .clock(clock),
    .reset(reset),
    .data (byteData),
    .valid(byteValid),
    .ready(byteReady),
    .txd  (txd)
  );

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Directed bench for nonce_uart_tx with CLKS_PER_BIT=4 (40 cycles per byte,
// 240 cycles per frame). Outputs are logged on falling edges and decoded.
module tb_nonce_uart_tx;

  localparam int CPB = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int FRAME_CYC = 6 * BYTE_CYC;
  localparam int LOG_LEN = 600;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        send = 1'b0;
  logic [31:0] nonce = 32'd0;
  logic        txd, busy, done;

  logic txdLog [0:LOG_LEN-1];
  logic busyLog[0:LOG_LEN-1];
  logic doneLog[0:LOG_LEN-1];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] nonce;
    int          pulseAt;
    logic [31:0] pulseNonce;
    bit          scramble;
    logic [47:0] expFrame;
  } vec_t;

  vec_t vecs[6];

  nonce_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock),
    .reset(reset),
    .send (send),
    .nonce(nonce),
    .txd  (txd),
    .busy (busy),
    .done (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Runs n cycles from the edge that samples the current inputs; log[i] is
  // the state after edge i. send stays high for sendCycles edges.
  task automatic capture(input int n, input int sendCycles, input int pulseAt,
                         input logic [31:0] pulseNonce, input bit scramble);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      txdLog[i]  = txd;
      busyLog[i] = busy;
      doneLog[i] = done;
      send = ((i + 1) < sendCycles) || ((i + 1) == pulseAt);
      if ((i + 1) == pulseAt) nonce = pulseNonce;
      else if (scramble) nonce = $urandom;
    end
    send = 1'b0;
  endtask

  // Decodes the six bytes starting at log index base
  task automatic checkFrame(input int base, input logic [47:0] exp, input string tag);
    for (int k = 0; k < 6; k++) begin
      int s;
      logic framingOk;
      logic [7:0] got;
      logic v;
      s = base + k * BYTE_CYC;
      framingOk = 1'b1;
      got = 8'd0;
      for (int b = 0; b < 10; b++) begin
        v = txdLog[s + b * CPB];
        for (int c = 1; c < CPB; c++) begin
          if (txdLog[s + b * CPB + c] !== v) framingOk = 1'b0;
        end
        if (b == 0 && v !== 1'b0) framingOk = 1'b0;
        else if (b == 9 && v !== 1'b1) framingOk = 1'b0;
        else if (b >= 1 && b <= 8) got[b-1] = v;
      end
      check($sformatf("%s byte%0d {framing,data}", tag, k), 64'({framingOk, got}),
            64'({1'b1, exp[47 - 8*k -: 8]}));
    end
  endtask

  // busy high for exactly the 240 frame cycles, then the done cycle
  task automatic checkBusyDone(input int base, input string tag);
    int cnt;
    cnt = 0;
    for (int i = base; i < base + FRAME_CYC; i++) if (busyLog[i] === 1'b1) cnt++;
    check($sformatf("%s busy cycles", tag), 64'(cnt), 64'(FRAME_CYC));
    check($sformatf("%s done cycle {busy,done,txd}", tag),
          64'({busyLog[base+FRAME_CYC], doneLog[base+FRAME_CYC], txdLog[base+FRAME_CYC]}),
          64'(3'b011));
  endtask

  function automatic int countDone(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (doneLog[i] === 1'b1) c++;
    return c;
  endfunction

  // Cycles in [from,n) where the line is not idle-high or busy/done is set
  function automatic int idleViolations(input int from, input int n);
    int c;
    c = 0;
    for (int i = from; i < n; i++)
      if (txdLog[i] !== 1'b1 || busyLog[i] !== 1'b0 || doneLog[i] !== 1'b0) c++;
    return c;
  endfunction

  initial begin
    int cnt;
    vecs[0] = '{32'h42A14695, -1, 32'h0,        1'b0, 48'hA5_42_A1_46_95_30};
    vecs[1] = '{32'h42A14695, 50, 32'hFFFFFFFF, 1'b0, 48'hA5_42_A1_46_95_30};
    vecs[2] = '{32'h12345678, -1, 32'h0,        1'b1, 48'hA5_12_34_56_78_08};
    vecs[3] = '{32'hDEADBEEF, -1, 32'h0,        1'b0, 48'hA5_DE_AD_BE_EF_22};
    vecs[4] = '{32'h00000000, -1, 32'h0,        1'b0, 48'hA5_00_00_00_00_00};
    vecs[5] = '{32'hFFFFFFFF, -1, 32'h0,        1'b1, 48'hA5_FF_FF_FF_FF_00};

    // Reset held, then released idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in reset {txd,busy,done}", 64'({txd, busy, done}), 64'(3'b100));
    reset = 1'b0;
    capture(100, 0, -1, 32'h0, 1'b0);
    check("idle after reset violations", 64'(idleViolations(0, 100)), 64'd0);

    // Single frames from the table
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      nonce = vecs[v].nonce;
      send = 1'b1;
      capture(300, 1, vecs[v].pulseAt, vecs[v].pulseNonce, vecs[v].scramble);
      check({tag, " txd falls after 1 cycle"}, 64'(txdLog[0]), 64'd0);
      checkFrame(0, vecs[v].expFrame, tag);
      checkBusyDone(0, tag);
      check({tag, " done pulses"}, 64'(countDone(300)), 64'd1);
      check({tag, " idle after frame"}, 64'(idleViolations(FRAME_CYC + 1, 300)), 64'd0);
    end

    // send held high: two back-to-back frames
    nonce = 32'h00000001;
    send = 1'b1;
    capture(560, 300, -1, 32'h0, 1'b0);
    checkFrame(0, 48'hA5_00_00_00_01_01, "held f1");
    checkBusyDone(0, "held f1");
    checkFrame(FRAME_CYC + 1, 48'hA5_00_00_00_01_01, "held f2");
    checkBusyDone(FRAME_CYC + 1, "held f2");
    check("held done pulses", 64'(countDone(560)), 64'd2);
    check("held idle after", 64'(idleViolations(2 * FRAME_CYC + 2, 560)), 64'd0);

    // Reset 100 cycles into a frame
    nonce = 32'h42A14695;
    send = 1'b1;
    capture(100, 1, -1, 32'h0, 1'b0);
    check("pre-reset busy", 64'(busyLog[99]), 64'd1);
    reset = 1'b1;
    #1;
    check("async reset {txd,busy,done}", 64'({txd, busy, done}), 64'(3'b100));
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) cnt++;
    end
    check("during reset violations", 64'(cnt), 64'd0);
    reset = 1'b0;
    capture(50, 0, -1, 32'h0, 1'b0);
    check("after mid-frame reset violations", 64'(idleViolations(0, 50)), 64'd0);
    nonce = 32'h12345678;
    send = 1'b1;
    capture(300, 1, -1, 32'h0, 1'b0);
    checkFrame(0, 48'hA5_12_34_56_78_08, "post-reset");
    checkBusyDone(0, "post-reset");
    check("post-reset done pulses", 64'(countDone(300)), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
